// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned NUM_RD_DEF = 2;
   localparam int unsigned MAX_RD     = 4;

   typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
   typedef logic [DATA_W_DEF-1:0] data_word_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: array/busy lookup, optional write bypass, zero-register override.
// Bypass is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    rd_en,
   input  logic [ADDR_W-1:0]       rd_addr,
   input  logic [DATA_W-1:0]       mem [2**ADDR_W],
   input  logic [2**ADDR_W-1:0]    busy,
`ifdef REGFILE_BYPASS_EN
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rsv_en,
   input  logic [ADDR_W-1:0]       rsv_addr,
`endif
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_valid,
   output logic                    rd_busy
);

   logic [DATA_W-1:0] nxt_data;
   logic              nxt_busy;

   // Value this port would capture at the coming edge
   always_comb begin
      nxt_data = mem[rd_addr];
      nxt_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr)) begin
         nxt_data = wr_data;
         nxt_busy = rsv_en && (rsv_addr == rd_addr);
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
         nxt_data = '0;
         nxt_busy = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_busy  <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= nxt_data;
            rd_busy <= nxt_busy;
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard; read ports are regfile_rd_port instances.
// Same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned NUM_RD   = NUM_RD_DEF,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       rsv_en,
   input  logic [ADDR_W-1:0]          rsv_addr,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_valid,
   output logic [NUM_RD-1:0]          rd_busy
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr_ok;
   logic              rsv_ok;

   assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
   assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

   // Reserve is applied after write so a same-cycle reservation wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_addr]  <= wr_data;
            busy[wr_addr] <= 1'b0;
         end
         if (rsv_ok) busy[rsv_addr] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_rd_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .clk      (clk),
         .reset_n  (reset_n),
         .rd_en    (rd_en[i]),
         .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
         .mem      (mem),
         .busy     (busy),
`ifdef REGFILE_BYPASS_EN
         .wr_en    (wr_en),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .rsv_en   (rsv_en),
         .rsv_addr (rsv_addr),
`endif
         .rd_data  (rd_data[i*DATA_W +: DATA_W]),
         .rd_valid (rd_valid[i]),
         .rd_busy  (rd_busy[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against an array model.
module tb_regfile_mp;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NR    = 2;
   localparam int unsigned DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic              rsv_en;
   logic [AW-1:0]     rsv_addr;
   logic [NR-1:0]     rd_en;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_valid;
   logic [NR-1:0]     rd_busy;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_busy  (rd_busy)
   );

   // Architectural model: register contents, pending flags, expected port outputs
   logic [DW-1:0]    ref_mem [DEPTH];
   logic [DEPTH-1:0] ref_busy;
   logic [DW-1:0]    exp_data  [NR];
   logic             exp_busy  [NR];
   logic             exp_valid [NR];

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int p = 0; p < NR; p++) begin
         chk($sformatf("%s data%0d", tag, p), rd_data[p*DW +: DW], exp_data[p]);
         chk($sformatf("%s valid%0d", tag, p), 32'(rd_valid[p]), 32'(exp_valid[p]));
         chk($sformatf("%s busy%0d", tag, p), 32'(rd_busy[p]), 32'(exp_busy[p]));
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      ref_busy = '0;
      for (int p = 0; p < NR; p++) begin
         exp_data[p]  = '0;
         exp_busy[p]  = 1'b0;
         exp_valid[p] = 1'b0;
      end
   endtask

   task automatic idle_in();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0;
      rd_en = '0; rd_addr = '0;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      rd_en[p] = 1'b1;
      rd_addr[p*AW +: AW] = a;
   endtask

   // Predict from current inputs, clock once, then compare
   task automatic step(input string tag);
      logic [DW-1:0] nd [NR];
      logic          nb [NR];
      logic [AW-1:0] a;
      for (int p = 0; p < NR; p++) begin
         a = rd_addr[p*AW +: AW];
         if (a == 0) begin
            nd[p] = '0; nb[p] = 1'b0;
         end else if (BYP && wr_en && wr_addr == a) begin
            nd[p] = wr_data; nb[p] = rsv_en && rsv_addr == a;
         end else begin
            nd[p] = ref_mem[a]; nb[p] = ref_busy[a];
         end
      end
      @(posedge clk);
      for (int p = 0; p < NR; p++) begin
         exp_valid[p] = rd_en[p];
         if (rd_en[p]) begin
            exp_data[p] = nd[p];
            exp_busy[p] = nb[p];
         end
      end
      if (wr_en && wr_addr != 0) begin
         ref_mem[wr_addr]  = wr_data;
         ref_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) ref_busy[rsv_addr] = 1'b1;
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
      return AW'($urandom);
   endfunction

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         idle_in();
         set_rd(0, AW'(i));
         set_rd(1, AW'(DEPTH - 1 - i));
         step(tag);
      end
      idle_in();
      step({tag, " idle"});
   endtask

   initial begin
      idle_in();
      model_clear();
      reset_n = 1'b0;
      #3;
      check_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;

      read_all_zero("post-reset");

      // r5 write then read, then an idle cycle to confirm single valid pulse
      idle_in(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; step("wr r5");
      idle_in(); set_rd(0, 5'd5); step("rd r5");
      idle_in(); step("rd r5 hold");

      // Zero register ignores writes and reservations
      idle_in(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; step("wr r0");
      idle_in(); set_rd(0, 5'd0); set_rd(1, 5'd0); step("rd r0");
      idle_in(); rsv_en = 1'b1; rsv_addr = 5'd0; step("rsv r0");
      idle_in(); set_rd(1, 5'd0); step("rd r0 busy");

      // Same-cycle write/read collision on r7
      idle_in(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000077; step("wr r7 old");
      idle_in(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; set_rd(1, 5'd7); step("wr+rd r7");
      idle_in(); set_rd(0, 5'd7); step("rd r7 after");

      // Scoreboard sequence on r9
      idle_in(); rsv_en = 1'b1; rsv_addr = 5'd9; step("rsv r9");
      idle_in(); set_rd(0, 5'd9); step("rd r9 busy");
      idle_in(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; step("wr r9");
      idle_in(); set_rd(0, 5'd9); step("rd r9 done");
      idle_in(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h66;
      rsv_en = 1'b1; rsv_addr = 5'd9; set_rd(1, 5'd9); step("wr+rsv r9");
      idle_in(); set_rd(0, 5'd9); set_rd(1, 5'd9); step("rd r9 rsv wins");

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         wr_en    = 1'($urandom_range(0, 1));
         wr_addr  = rnd_addr();
         wr_data  = $urandom();
         rsv_en   = ($urandom_range(0, 3) == 0);
         rsv_addr = rnd_addr();
         rd_en    = NR'($urandom);
         for (int p = 0; p < NR; p++) rd_addr[p*AW +: AW] = rnd_addr();
         step("random");
      end

      // Reset one cycle after a read request
      idle_in(); set_rd(0, 5'd5); set_rd(1, 5'd9); step("pre-reset rd");
      idle_in();
      #2;
      reset_n = 1'b0;
      #1;
      model_clear();
      check_outputs("mid reset");
      @(negedge clk);
      reset_n = 1'b1;
      read_all_zero("after mid reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
